mirror_mode_select: RTL and testbench

Upstream control stage for the rear-view mirror display multiplexer. It turns the driver's raw mode push-button into the 2-bit select code SS that picks Temperature (00), Average_mpg (01), Instantaneous_mpg (10) or Miles_remaining (11) for the mirror Display. The block synchronises and debounces the button and advances SS once per clean press. After a period of inactivity it reverts SS to Temperature.

---
 rtl/mirror_mode_select.sv | 128 ++++++++++++
 tb/tb_mirror_mode_select.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mirror_mode_select.sv
// Mirror display mode selector: synchronises and debounces the driver's mode
// button, steps the 2-bit display select once per clean press, and falls back
// to Temperature (00) after a period without presses.
module mirror_mode_select #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned IDLE_TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Mode_btn,
    input  logic       Freeze,
    output logic [1:0] SS,
    output logic       Mode_changed,
    output logic       Btn_level
);

    localparam int unsigned SS_W   = 2;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT) + 1;

    // Counter value on which the next mismatch is the accepting one.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    // Idle count at which the next increment becomes a timeout instead.
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [SS_W-1:0]   SS_TEMP   = SS_W'(0);

    logic              sync_s1;
    logic              sync_s2;
    logic [DB_W-1:0]   db_cnt;
    logic              btn_q;
    logic [IDLE_W-1:0] idle_cnt;

    logic [DB_W-1:0]   db_cnt_nxt_c;
    logic              btn_level_nxt_c;
    logic              press_c;
    logic              press_accept_c;
    logic              ss_is_temp_c;
    logic              timeout_c;
    logic [SS_W-1:0]   ss_nxt_c;
    logic              mode_changed_nxt_c;
    logic [IDLE_W-1:0] idle_nxt_c;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
        end else begin
            sync_s1 <= Mode_btn;
            sync_s2 <= sync_s1;
        end
    end

    // Debounce: count consecutive disagreements, accept the new level on the last one.
    always_comb begin
        db_cnt_nxt_c    = '0;
        btn_level_nxt_c = Btn_level;
        if (sync_s2 != Btn_level) begin
            if (db_cnt == DB_LAST) begin
                btn_level_nxt_c = sync_s2;
            end else begin
                db_cnt_nxt_c = db_cnt + DB_W'(1);
            end
        end
    end

    // Debounced level and its counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt    <= '0;
            Btn_level <= 1'b0;
        end else begin
            db_cnt    <= db_cnt_nxt_c;
            Btn_level <= btn_level_nxt_c;
        end
    end

    // Delayed debounced level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= Btn_level;
        end
    end

    // Press/timeout arbitration; an accepted press always beats a coincident timeout.
    always_comb begin
        ss_nxt_c           = SS;
        mode_changed_nxt_c = 1'b0;
        idle_nxt_c         = idle_cnt;

        press_c        = Btn_level & ~btn_q;
        press_accept_c = press_c & ~Freeze;
        ss_is_temp_c   = (SS == SS_TEMP);
        timeout_c      = ~ss_is_temp_c & ~Freeze & (idle_cnt == IDLE_LAST);

        if (press_accept_c) begin
            ss_nxt_c           = SS + SS_W'(1);
            mode_changed_nxt_c = 1'b1;
            idle_nxt_c         = '0;
        end else if (ss_is_temp_c) begin
            idle_nxt_c = '0;
        end else if (Freeze) begin
            idle_nxt_c = idle_cnt;
        end else if (timeout_c) begin
            ss_nxt_c           = SS_TEMP;
            mode_changed_nxt_c = 1'b1;
            idle_nxt_c         = '0;
        end else begin
            idle_nxt_c = idle_cnt + IDLE_W'(1);
        end
    end

    // Select code, change pulse and idle timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            SS           <= SS_TEMP;
            Mode_changed <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            SS           <= ss_nxt_c;
            Mode_changed <= mode_changed_nxt_c;
            idle_cnt     <= idle_nxt_c;
        end
    end

endmodule

// File: tb/tb_mirror_mode_select.sv
// Bench for mirror_mode_select: expected select changes are queued with the
// cycle they must appear in, and every Mode_changed pulse is matched against them.
module tb_mirror_mode_select;

    localparam int unsigned DB = 4;
    localparam int unsigned TO = 16;
    // Cycles from driving a clean press (at a negedge) to the select update.
    localparam int ADV_LAT = DB + 3;

    logic       clk;
    logic       rst;
    logic       Mode_btn;
    logic       Freeze;
    logic [1:0] SS;
    logic       Mode_changed;
    logic       Btn_level;

    mirror_mode_select #(
        .DEBOUNCE_CYCLES(DB),
        .IDLE_TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Mode_btn    (Mode_btn),
        .Freeze      (Freeze),
        .SS          (SS),
        .Mode_changed(Mode_changed),
        .Btn_level   (Btn_level)
    );

    typedef struct {
        logic [1:0] ss;
        int         cyc;
    } exp_t;

    typedef struct {
        logic       freeze;
        logic       adv;
        logic [1:0] exp_ss;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] ss, input int at);
        exp_t e;
        e.ss  = ss;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every change pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL missed_change: no pulse, expected SS=%0d at cycle %0d", sb[0].ss, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (Mode_changed) begin
                pulses++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_change: SS=%0d at cycle %0d, none expected", SS, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("change_ss", int'(SS), int'(mon_e.ss));
                    chk("change_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   c, a, b, x, last, p0, exp_adv;

        vecs[0] = '{freeze: 1'b0, adv: 1'b1, exp_ss: 2'b01};
        vecs[1] = '{freeze: 1'b0, adv: 1'b1, exp_ss: 2'b10};
        vecs[2] = '{freeze: 1'b0, adv: 1'b1, exp_ss: 2'b11};
        vecs[3] = '{freeze: 1'b0, adv: 1'b1, exp_ss: 2'b00};
        vecs[4] = '{freeze: 1'b1, adv: 1'b0, exp_ss: 2'b00};
        vecs[5] = '{freeze: 1'b0, adv: 1'b1, exp_ss: 2'b01};

        rst      = 1'b1;
        Mode_btn = 1'b0;
        Freeze   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ss", int'(SS), 0);
        chk("reset_changed", int'(Mode_changed), 0);
        chk("reset_btn_level", int'(Btn_level), 0);

        // Long hold: one advance, debounce latency, then idle timeout back to 00.
        c = cyc;
        Mode_btn = 1'b1;
        push(2'b01, c + ADV_LAT);
        push(2'b00, c + ADV_LAT + TO);
        wait_until(c + 5);
        chk("t1_level_before", int'(Btn_level), 0);
        wait_until(c + 6);
        chk("t1_level_after", int'(Btn_level), 1);
        wait_until(c + 20);
        Mode_btn = 1'b0;
        wait_until(c + 25);
        chk("t1_release_before", int'(Btn_level), 1);
        wait_until(c + 26);
        chk("t1_release_after", int'(Btn_level), 0);
        chk("t4_after_timeout", int'(SS), 0);
        wait_until(c + 60);
        chk("t4_stays_temp", int'(SS), 0);

        // Bounce then stable hold.
        b = cyc;
        for (int i = 0; i < 4; i++) begin
            Mode_btn = (i % 2 == 0);
            @(negedge clk);
        end
        Mode_btn = 1'b1;
        push(2'b01, b + 4 + ADV_LAT);
        push(2'b00, b + 4 + ADV_LAT + TO);
        wait_until(b + 8);
        chk("t2_no_change_bounce", int'(SS), 0);
        wait_until(b + 9);
        chk("t2_level_bounce", int'(Btn_level), 0);
        wait_until(b + 16);
        Mode_btn = 1'b0;
        wait_until(b + 40);
        chk("t2_timed_out", int'(SS), 0);

        // Table: presses 12 cycles apart, including wrap and a frozen press.
        p0 = pulses;
        exp_adv = 0;
        last = cyc;
        for (int i = 0; i < 6; i++) begin
            c = cyc;
            Freeze   = vecs[i].freeze;
            Mode_btn = 1'b1;
            if (vecs[i].adv) begin
                push(vecs[i].exp_ss, c + ADV_LAT);
                last = c + ADV_LAT;
                exp_adv++;
            end
            wait_until(c + 5);
            Mode_btn = 1'b0;
            wait_until(c + 12);
            chk($sformatf("table_ss_%0d", i), int'(SS), int'(vecs[i].exp_ss));
            Freeze = 1'b0;
        end
        chk("table_pulses", pulses - p0, exp_adv);
        push(2'b00, last + TO);
        wait_until(last + 30);
        chk("table_timed_out", int'(SS), 0);

        // Freeze holds the idle timer and drops a press.
        c = cyc;
        a = c + ADV_LAT;
        Mode_btn = 1'b1;
        push(2'b01, a);
        wait_until(c + 5);
        Mode_btn = 1'b0;
        wait_until(a + 5);
        Freeze = 1'b1;
        wait_until(a + 15);
        Mode_btn = 1'b1;
        wait_until(a + 23);
        Mode_btn = 1'b0;
        wait_until(a + 44);
        chk("t5_frozen_ss", int'(SS), 1);
        wait_until(a + 45);
        Freeze = 1'b0;
        push(2'b00, a + 56);
        wait_until(a + 55);
        chk("t5_before_timeout", int'(SS), 1);
        wait_until(a + 56);
        chk("t5_at_timeout", int'(SS), 0);
        wait_until(a + 70);

        // Press landing on the timeout edge wins.
        c = cyc;
        a = c + ADV_LAT;
        Mode_btn = 1'b1;
        push(2'b01, a);
        wait_until(c + 5);
        Mode_btn = 1'b0;
        wait_until(a + TO - ADV_LAT);
        Mode_btn = 1'b1;
        push(2'b10, a + TO);
        push(2'b00, a + 2 * TO);
        wait_until(a + 14);
        Mode_btn = 1'b0;
        wait_until(a + TO);
        chk("t5b_press_wins", int'(SS), 2);
        wait_until(a + 40);
        chk("t5b_timed_out", int'(SS), 0);

        // Reset mid-debounce with SS=10, button still held.
        x = cyc;
        Mode_btn = 1'b1;
        push(2'b01, x + ADV_LAT);
        wait_until(x + 5);
        Mode_btn = 1'b0;
        wait_until(x + 12);
        Mode_btn = 1'b1;
        push(2'b10, x + 12 + ADV_LAT);
        wait_until(x + 17);
        Mode_btn = 1'b0;
        c = x + 24;
        wait_until(c);
        Mode_btn = 1'b1;
        wait_until(c + 5);
        chk("t6_ss_before_rst", int'(SS), 2);
        rst = 1'b1;
        wait_until(c + 6);
        rst = 1'b0;
        chk("t6_rst_ss", int'(SS), 0);
        chk("t6_rst_level", int'(Btn_level), 0);
        chk("t6_rst_changed", int'(Mode_changed), 0);
        push(2'b01, c + 6 + ADV_LAT);
        push(2'b00, c + 6 + ADV_LAT + TO);
        wait_until(c + 11);
        chk("t6_level_before", int'(Btn_level), 0);
        wait_until(c + 12);
        chk("t6_level_after", int'(Btn_level), 1);
        wait_until(c + 20);
        Mode_btn = 1'b0;
        wait_until(c + 45);
        chk("t6_final_ss", int'(SS), 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
